// File: rtl/issue_sched_pkg.sv
// issue_sched_pkg: shared field ranges, exception width and FSM encodings for the issue stage
package issue_sched_pkg;

    localparam int REG_W   = 5;
    localparam int EXC_W   = 6;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] op);
        return op[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] op);
        return op[RS2_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rd_of(input logic [31:0] op);
        return op[RD_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/issue_sched_bypass.sv
// issue_bypass: picks one source operand from x0, E1 ALU, E2, WB or register file, youngest first
module issue_bypass
    import issue_sched_pkg::*;
(
    input  logic [REG_W-1:0] idx_i,
    input  logic [REG_W-1:0] rd_e1_i,
    input  logic             e1_fwd_i,
    input  logic [31:0]      e1_val_i,
    input  logic [REG_W-1:0] rd_e2_i,
    input  logic [31:0]      e2_val_i,
    input  logic [REG_W-1:0] rd_wb_i,
    input  logic [31:0]      wb_val_i,
    input  logic [31:0]      rf_val_i,
    output logic [31:0]      operand_o
);

    // idx_i != 0 guarantees a zero stage rd never matches, so rd==0 means no writer
    always_comb begin
        operand_o = (idx_i == '0)                      ? 32'd0    :
                    (e1_fwd_i && idx_i == rd_e1_i)     ? e1_val_i :
                    (idx_i == rd_e2_i)                 ? e2_val_i :
                    (idx_i == rd_wb_i)                 ? wb_val_i : rf_val_i;
    end

endmodule

// File: rtl/issue_sched.sv
// issue_sched: single-issue front of the execute pipe with scoreboard, bypass and divider serialisation
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
    parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    output logic             fetch_accept_o,
    input  logic [31:0]      fetch_pc_i,
    input  logic [31:0]      fetch_opcode_i,
    input  logic             fetch_lsu_i,
    input  logic             fetch_csr_i,
    input  logic             fetch_div_i,
    input  logic             fetch_mul_i,
    input  logic             fetch_branch_i,
    input  logic             fetch_rd_valid_i,
    input  logic             fetch_ra_valid_i,
    input  logic             fetch_rb_valid_i,
    input  logic [EXC_W-1:0] fetch_exception_i,
    output logic [REG_W-1:0] rf_ra_idx_o,
    output logic [REG_W-1:0] rf_rb_idx_o,
    input  logic [31:0]      rf_ra_value_i,
    input  logic [31:0]      rf_rb_value_i,
    input  logic [REG_W-1:0] rd_e1_i,
    input  logic             load_e1_i,
    input  logic             mul_e1_i,
    input  logic [31:0]      alu_result_e1_i,
    input  logic [REG_W-1:0] rd_e2_i,
    input  logic [31:0]      result_e2_i,
    input  logic [REG_W-1:0] rd_wb_i,
    input  logic [31:0]      result_wb_i,
    input  logic             pipe_stall_i,
    input  logic             squash_i,
    input  logic             div_complete_i,
    output logic             issue_valid_o,
    output logic             issue_accept_o,
    output logic             issue_stall_o,
    output logic             issue_lsu_o,
    output logic             issue_csr_o,
    output logic             issue_div_o,
    output logic             issue_mul_o,
    output logic             issue_branch_o,
    output logic             issue_rd_valid_o,
    output logic [REG_W-1:0] issue_rd_o,
    output logic [31:0]      issue_pc_o,
    output logic [31:0]      issue_opcode_o,
    output logic [31:0]      issue_operand_ra_o,
    output logic [31:0]      issue_operand_rb_o,
    output logic [EXC_W-1:0] issue_exception_o
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      sb_q, sb_d;
    logic             div_busy_q, div_busy_d;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic [31:0]      wb_clr, sb_live, sb_set;
    logic             ra_used, rb_used, e1_late, hazard, div_issue, sb_class;

    assign rs1 = rs1_of(fetch_opcode_i);
    assign rs2 = rs2_of(fetch_opcode_i);
    assign rd  = rd_of(fetch_opcode_i);

    assign rf_ra_idx_o = rs1;
    assign rf_rb_idx_o = rs2;

    assign issue_stall_o     = pipe_stall_i;
    assign issue_lsu_o       = fetch_lsu_i;
    assign issue_csr_o       = fetch_csr_i;
    assign issue_div_o       = fetch_div_i;
    assign issue_mul_o       = fetch_mul_i;
    assign issue_branch_o    = fetch_branch_i;
    assign issue_rd_valid_o  = fetch_rd_valid_i;
    assign issue_rd_o        = rd & {REG_W{fetch_rd_valid_i}};
    assign issue_pc_o        = fetch_pc_i;
    assign issue_opcode_o    = fetch_opcode_i;
    assign issue_exception_o = fetch_exception_i;

    // a WB write releases its scoreboard bit in the same cycle, since the value is forwarded from WB
    assign wb_clr  = (rd_wb_i != '0) ? (32'd1 << rd_wb_i) : 32'd0;
    assign sb_live = sb_q & ~wb_clr;

    assign ra_used = fetch_ra_valid_i && rs1 != '0;
    assign rb_used = fetch_rb_valid_i && rs2 != '0;
    assign e1_late = load_e1_i || mul_e1_i;

    // RAW against long-latency writers in the scoreboard, load/mul still in E1, or a busy divider
    always_comb begin
        hazard = (ra_used && (sb_live[rs1] || (e1_late && rs1 == rd_e1_i))) ||
                 (rb_used && (sb_live[rs2] || (e1_late && rs2 == rd_e1_i))) ||
                 (fetch_div_i && div_busy_q);
    end

    assign issue_valid_o  = fetch_valid_i && state_q == ST_RUN && !squash_i;
    assign issue_accept_o = issue_valid_o && !hazard;
    assign fetch_accept_o = issue_accept_o && !pipe_stall_i;
    assign div_issue      = fetch_accept_o && fetch_div_i;

    assign sb_class = fetch_div_i || fetch_csr_i ||
                      (fetch_lsu_i && !SUPPORT_LOAD_BYPASS) ||
                      (fetch_mul_i && !SUPPORT_MUL_BYPASS);
    assign sb_set   = (fetch_accept_o && fetch_rd_valid_i && rd != '0 && sb_class) ?
                      (32'd1 << rd) : 32'd0;

    issue_bypass u_byp_ra (
        .idx_i     (rs1),
        .rd_e1_i   (rd_e1_i),
        .e1_fwd_i  (!e1_late),
        .e1_val_i  (alu_result_e1_i),
        .rd_e2_i   (rd_e2_i),
        .e2_val_i  (result_e2_i),
        .rd_wb_i   (rd_wb_i),
        .wb_val_i  (result_wb_i),
        .rf_val_i  (rf_ra_value_i),
        .operand_o (issue_operand_ra_o)
    );

    issue_bypass u_byp_rb (
        .idx_i     (rs2),
        .rd_e1_i   (rd_e1_i),
        .e1_fwd_i  (!e1_late),
        .e1_val_i  (alu_result_e1_i),
        .rd_e2_i   (rd_e2_i),
        .e2_val_i  (result_e2_i),
        .rd_wb_i   (rd_wb_i),
        .wb_val_i  (result_wb_i),
        .rf_val_i  (rf_rb_value_i),
        .operand_o (issue_operand_rb_o)
    );

    // next state: squash beats stall, stall freezes everything but the divider-done release
    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        div_busy_d = div_busy_q && !div_complete_i;
        if (squash_i) begin
            state_d    = ST_FLUSH;
            sb_d       = 32'd0;
            div_busy_d = 1'b0;
        end else if (!pipe_stall_i) begin
            sb_d       = sb_live | sb_set;
            state_d    = (state_q == ST_FLUSH)    ? ST_RUN :
                         (state_q == ST_DIV_WAIT) ? ((div_complete_i || !div_busy_q) ? ST_RUN : ST_DIV_WAIT) :
                         (div_issue ? ST_DIV_WAIT : ST_RUN);
            div_busy_d = div_issue || div_busy_d;
        end
    end

    // state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            sb_q       <= 32'd0;
            div_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            div_busy_q <= div_busy_d;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed table plus hand sequences for the issue scheduler
module tb_issue_sched;

    localparam logic [31:0] RV = 32'h1111_1111;
    localparam logic [31:0] BV = 32'h2222_2222;
    localparam logic [31:0] AV = 32'h0000_0010;
    localparam logic [31:0] EV = 32'hDEAD_BEEF;
    localparam logic [31:0] WV = 32'hCAFE_0000;

    // flag bits: rd_valid, ra_valid, rb_valid, lsu, csr, div, mul, branch
    localparam logic [7:0] F_ALU  = 8'b1110_0000;
    localparam logic [7:0] F_ALUI = 8'b1100_0000;
    localparam logic [7:0] F_LW   = 8'b1101_0000;
    localparam logic [7:0] F_DIV  = 8'b1110_0100;
    localparam logic [7:0] F_CSR  = 8'b1100_1000;
    localparam logic [7:0] F_NORD = 8'b0110_0000;

    logic clk = 1'b0, rst = 1'b1;
    logic fv, fa, lsu, csr, dv, ml, br, rdv, rav, rbv;
    logic [31:0] pc, op, rav_v, rbv_v, alu_e1, res_e2, res_wb;
    logic [5:0] exc;
    logic [4:0] ra_idx, rb_idx, rd_e1, rd_e2, rd_wb;
    logic ld_e1, ml_e1, stall, squash, dcomp;
    logic iv, ia, is, ilsu, icsr, idiv, imul, ibr, irdv;
    logic [4:0] ird;
    logic [31:0] ipc, iop, ira, irb;
    logic [5:0] iexc;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    issue_sched dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fv), .fetch_accept_o(fa), .fetch_pc_i(pc), .fetch_opcode_i(op),
        .fetch_lsu_i(lsu), .fetch_csr_i(csr), .fetch_div_i(dv), .fetch_mul_i(ml),
        .fetch_branch_i(br), .fetch_rd_valid_i(rdv), .fetch_ra_valid_i(rav), .fetch_rb_valid_i(rbv),
        .fetch_exception_i(exc), .rf_ra_idx_o(ra_idx), .rf_rb_idx_o(rb_idx),
        .rf_ra_value_i(rav_v), .rf_rb_value_i(rbv_v),
        .rd_e1_i(rd_e1), .load_e1_i(ld_e1), .mul_e1_i(ml_e1), .alu_result_e1_i(alu_e1),
        .rd_e2_i(rd_e2), .result_e2_i(res_e2), .rd_wb_i(rd_wb), .result_wb_i(res_wb),
        .pipe_stall_i(stall), .squash_i(squash), .div_complete_i(dcomp),
        .issue_valid_o(iv), .issue_accept_o(ia), .issue_stall_o(is),
        .issue_lsu_o(ilsu), .issue_csr_o(icsr), .issue_div_o(idiv), .issue_mul_o(imul),
        .issue_branch_o(ibr), .issue_rd_valid_o(irdv), .issue_rd_o(ird),
        .issue_pc_o(ipc), .issue_opcode_o(iop),
        .issue_operand_ra_o(ira), .issue_operand_rb_o(irb), .issue_exception_o(iexc)
    );

    typedef struct {
        logic [7:0]  f;
        logic [4:0]  rs1, rs2, rd, e1, e2, wb;
        logic        ld, ml, st, sq, fv;
        logic        ev, ea, efa;
        logic [31:0] era, erb;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic head(input logic [7:0] f, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        fv = 1'b1;
        {rdv, rav, rbv, lsu, csr, dv, ml, br} = f;
        op = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
        pc = 32'h100 + {22'd0, rd, 5'd0};
        exc = 6'd0;
    endtask

    task automatic fb(input logic [4:0] e1, input logic l, input logic m, input logic [4:0] e2, input logic [4:0] wb);
        rd_e1 = e1; ld_e1 = l; ml_e1 = m; rd_e2 = e2; rd_wb = wb;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rav_v = RV; rbv_v = BV; alu_e1 = AV; res_e2 = EV; res_wb = WV;
        stall = 0; squash = 0; dcomp = 0;
        fb(0, 0, 0, 0, 0);
        head(F_ALU, 1, 2, 5);

        vecs[0]  = '{F_ALU,  1, 2, 5,  0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, RV, BV, 5};
        vecs[1]  = '{F_ALUI, 5, 2, 6,  5, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, AV, BV, 6};
        vecs[2]  = '{F_ALU,  7, 7, 8,  7, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, RV, BV, 8};
        vecs[3]  = '{F_ALU,  7, 7, 8,  0, 7, 0, 0, 0, 0, 0, 1, 1, 1, 1, EV, EV, 8};
        vecs[4]  = '{F_ALU,  9, 2, 11, 0, 0, 9, 0, 0, 0, 0, 1, 1, 1, 1, WV, BV, 11};
        vecs[5]  = '{F_ALU,  3, 3, 4,  3, 3, 3, 0, 0, 0, 0, 1, 1, 1, 1, AV, AV, 4};
        vecs[6]  = '{F_ALU,  3, 2, 4,  0, 3, 3, 0, 0, 0, 0, 1, 1, 1, 1, EV, BV, 4};
        vecs[7]  = '{F_ALU,  0, 0, 4,  0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0,  0,  4};
        vecs[8]  = '{F_ALU,  1, 4, 5,  4, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, RV, BV, 5};
        vecs[9]  = '{F_ALUI, 1, 7, 5,  7, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, RV, BV, 5};
        vecs[10] = '{F_ALU,  1, 2, 5,  0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, RV, BV, 5};
        vecs[11] = '{F_ALU,  1, 2, 5,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, RV, BV, 5};
        vecs[12] = '{F_ALU,  1, 2, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RV, BV, 5};
        vecs[13] = '{F_NORD, 1, 2, 5,  0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, RV, BV, 0};

        // combinational table, evaluated with reset held so the state stays at zero
        tick();
        chk("reset_state", {30'd0, dut.state_q}, 32'd0);
        chk("reset_sb", dut.sb_q, 32'd0);
        for (int i = 0; i < 14; i++) begin
            head(vecs[i].f, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            fv = vecs[i].fv;
            fb(vecs[i].e1, vecs[i].ld, vecs[i].ml, vecs[i].e2, vecs[i].wb);
            stall = vecs[i].st;
            squash = vecs[i].sq;
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, iv}, {31'd0, vecs[i].ev});
            chk($sformatf("v%0d_accept", i), {31'd0, ia}, {31'd0, vecs[i].ea});
            chk($sformatf("v%0d_fetch_accept", i), {31'd0, fa}, {31'd0, vecs[i].efa});
            chk($sformatf("v%0d_ra", i), ira, vecs[i].era);
            chk($sformatf("v%0d_rb", i), irb, vecs[i].erb);
            chk($sformatf("v%0d_rd", i), {27'd0, ird}, {27'd0, vecs[i].erd});
            chk($sformatf("v%0d_stall", i), {31'd0, is}, {31'd0, vecs[i].st});
        end
        stall = 0; squash = 0;
        fb(0, 0, 0, 0, 0);
        head(F_ALU, 1, 2, 5);
        tick();
        rst = 0;
        tick();

        // back-to-back ALU with E1 bypass
        head(F_ALU, 1, 2, 5); #1;
        chk("b2b_first", {31'd0, fa}, 32'd1);
        tick();
        head(F_ALUI, 5, 0, 6); fb(5, 0, 0, 0, 0); #1;
        chk("b2b_second", {31'd0, fa}, 32'd1);
        chk("b2b_ra", ira, AV);
        tick();

        // load-use: one bubble, then E2 forward
        head(F_LW, 1, 0, 7); fb(0, 0, 0, 0, 0); #1;
        chk("lw_issue", {31'd0, fa}, 32'd1);
        tick();
        head(F_ALU, 7, 7, 8); fb(7, 1, 0, 0, 0); #1;
        chk("lu_stall", {31'd0, ia}, 32'd0);
        tick();
        fb(0, 0, 0, 7, 0); #1;
        chk("lu_issue", {31'd0, fa}, 32'd1);
        chk("lu_ra", ira, EV);
        chk("lu_rb", irb, EV);
        chk("lu_sb", dut.sb_q, 32'd0);
        tick();

        // divider serialisation and WB-released consumer
        head(F_DIV, 1, 2, 9); fb(0, 0, 0, 0, 0); #1;
        chk("div1_issue", {31'd0, fa}, 32'd1);
        tick();
        chk("div_wait_state", {30'd0, dut.state_q}, 32'd1);
        chk("div_sb", dut.sb_q, 32'h0000_0200);
        head(F_DIV, 1, 2, 10); #1;
        for (int i = 0; i < 3; i++) begin
            chk("div2_blocked", {31'd0, fa}, 32'd0);
            tick();
        end
        dcomp = 1; #1;
        chk("div2_blocked_done", {31'd0, iv}, 32'd0);
        tick();
        dcomp = 0;
        chk("div_run_state", {30'd0, dut.state_q}, 32'd0);
        head(F_ALU, 9, 2, 11); #1;
        chk("div_use_valid", {31'd0, iv}, 32'd1);
        chk("div_use_stall", {31'd0, ia}, 32'd0);
        tick();
        fb(0, 0, 0, 0, 9); #1;
        chk("div_use_issue", {31'd0, fa}, 32'd1);
        chk("div_use_ra", ira, WV);
        tick();
        fb(0, 0, 0, 0, 0);
        chk("div_sb_clear", dut.sb_q, 32'd0);

        // squash during DIV_WAIT
        head(F_DIV, 1, 2, 10); #1;
        chk("div3_issue", {31'd0, fa}, 32'd1);
        tick();
        head(F_ALU, 1, 2, 12);
        squash = 1; #1;
        chk("sq_valid", {31'd0, iv}, 32'd0);
        chk("sq_fa", {31'd0, fa}, 32'd0);
        tick();
        squash = 0; #1;
        chk("flush_state", {30'd0, dut.state_q}, 32'd2);
        chk("flush_sb", dut.sb_q, 32'd0);
        chk("flush_fa", {31'd0, fa}, 32'd0);
        tick();
        chk("flush_exit", {31'd0, fa}, 32'd1);
        chk("flush_divbusy", {31'd0, dut.div_busy_q}, 32'd0);
        tick();

        // rd==0 leaves the scoreboard alone, then pipe stall freezes it
        head(F_CSR, 1, 0, 0); #1;
        chk("csr0_issue", {31'd0, fa}, 32'd1);
        tick();
        chk("csr0_sb", dut.sb_q, 32'd0);
        head(F_CSR, 1, 0, 13); #1;
        tick();
        chk("csr_sb", dut.sb_q, 32'h0000_2000);
        head(F_ALU, 1, 2, 14); fb(0, 0, 0, 0, 13); stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fa", {31'd0, fa}, 32'd0);
            chk("stall_valid", {31'd0, iv}, 32'd1);
            tick();
            chk("stall_sb", dut.sb_q, 32'h0000_2000);
        end
        stall = 0; #1;
        chk("stall_release_fa", {31'd0, fa}, 32'd1);
        tick();
        fb(0, 0, 0, 0, 0);
        chk("stall_release_sb", dut.sb_q, 32'd0);

        // reset in the middle of a divide
        head(F_DIV, 1, 2, 15); #1;
        tick();
        chk("rst_pre_state", {30'd0, dut.state_q}, 32'd1);
        rst = 1; #1;
        chk("rst_state", {30'd0, dut.state_q}, 32'd0);
        chk("rst_sb", dut.sb_q, 32'd0);
        chk("rst_valid_hi", {31'd0, iv}, 32'd1);
        fv = 0; #1;
        chk("rst_valid_lo", {31'd0, iv}, 32'd0);
        tick();
        rst = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
